// File: rtl/csr_uart_pkg.sv
// Shared CSR addresses, UART status bit positions and FSM state encoding.
package csr_uart_pkg;

  localparam logic [11:0] CSR_UART = 12'hbc0;
  // Simulation-only character print port; decoded outside this block.
  localparam logic [11:0] CSR_SIM  = 12'hbc1;

  localparam logic [2:0] MOD_WRITE = 3'd1;

  localparam int ST_RX_VALID     = 8;
  localparam int ST_TX_FULL      = 9;
  localparam int ST_TX_IDLE      = 10;
  localparam int ST_RX_OVERRUN   = 11;
  localparam int ST_RX_FRAME_ERR = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_state_e;

endpackage

// File: rtl/csr_uart_if.sv
// CSR port bundle: request side driven by the pipeline, response by the peripheral.
interface csr_uart_if;
  logic        read;
  logic [2:0]  modify;
  logic [31:0] wdata;
  logic [11:0] addr;
  logic [31:0] rdata;
  logic        valid;

  modport master (output read, modify, wdata, addr, input rdata, valid);
  modport slave  (input read, modify, wdata, addr, output rdata, valid);
endinterface

// File: rtl/csr_uart_sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit to tell full from empty.
module csr_uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int LOG   = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 2 ** LOG;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LOG:0]     wr_ptr;
  logic [LOG:0]     rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[LOG] != rd_ptr[LOG]) && (wr_ptr[LOG-1:0] == rd_ptr[LOG-1:0]);
  assign rdata = mem[rd_ptr[LOG-1:0]];

  // Pointer update; a push while full is dropped, a pop while empty is ignored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[LOG-1:0]] <= wdata;
  end

endmodule

// File: rtl/csr_uart.sv
// CSR-mapped 8N1 UART: TX bytes queue in a FIFO, RX keeps one byte for software.
module csr_uart
  import csr_uart_pkg::*;
#(
  parameter int CLOCK_DIVIDE = 868,
  parameter int FIFO_LOG     = 3
) (
  input  logic      clk,
  input  logic      rstn,
  csr_uart_if.slave bus,
  output logic      tx,
  input  logic      rx
);

  localparam int BAUD_W = (CLOCK_DIVIDE > 2) ? $clog2(CLOCK_DIVIDE) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCK_DIVIDE - 1);
  // Edge detection already costs a cycle, so the start sample lands at CLOCK_DIVIDE/2.
  localparam logic [BAUD_W-1:0] BAUD_MID  = BAUD_W'((CLOCK_DIVIDE / 2) - 1);

  logic [11:0]       addr_p1;
  logic              read_p1, hit_p1, push_p1;
  logic [31:0]       status;
  logic [7:0]        fifo_rdata;
  logic              fifo_empty, fifo_full, tx_idle;
  uart_state_e       tx_state, tx_state_n, rx_state, rx_state_n;
  logic [7:0]        tx_shift, tx_shift_n, rx_shift, rx_shift_n;
  logic [2:0]        tx_bit, tx_bit_n, rx_bit, rx_bit_n;
  logic [BAUD_W-1:0] tx_baud, tx_baud_n, rx_baud, rx_baud_n;
  logic              tx_pop, rx_done_ok, rx_done_bad;
  logic              rx_meta, rx_sync, rx_prev;
  logic [7:0]        rx_byte;
  logic              rx_valid, rx_overrun, rx_frame_err;
  logic              unused_wdata;

  assign unused_wdata = ^bus.wdata[31:8];

  // Request stage: capture address and read so the data phase follows one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_p1 <= '0;
      read_p1 <= 1'b0;
    end else begin
      addr_p1 <= bus.addr;
      read_p1 <= bus.read && (bus.addr == CSR_UART);
    end
  end

  assign hit_p1    = (addr_p1 == CSR_UART);
  assign push_p1   = hit_p1 && (bus.modify == MOD_WRITE);
  assign tx_idle   = fifo_empty && (tx_state == S_IDLE);
  assign bus.valid = read_p1 || (hit_p1 && (bus.modify != 3'd0));
  assign bus.rdata = read_p1 ? status : 32'h0;

  // Status word as seen in the data phase, before any read-clear takes effect.
  always_comb begin
    status                  = '0;
    status[7:0]             = rx_byte;
    status[ST_RX_VALID]     = rx_valid;
    status[ST_TX_FULL]      = fifo_full;
    status[ST_TX_IDLE]      = tx_idle;
    status[ST_RX_OVERRUN]   = rx_overrun;
    status[ST_RX_FRAME_ERR] = rx_frame_err;
  end

  csr_uart_sync_fifo #(.WIDTH(8), .LOG(FIFO_LOG)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_p1),
    .wdata (bus.wdata[7:0]),
    .pop   (tx_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // TX next state: pop only on a registered non-empty FIFO, chain frames from STOP.
  always_comb begin
    tx_state_n = tx_state;
    tx_shift_n = tx_shift;
    tx_bit_n   = tx_bit;
    tx_baud_n  = tx_baud + 1'b1;
    tx_pop     = 1'b0;
    case (tx_state)
      S_IDLE: begin
        tx_baud_n = '0;
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = fifo_rdata;
          tx_bit_n   = '0;
          tx_state_n = S_START;
        end
      end
      S_START: begin
        if (tx_baud == BAUD_LAST) begin
          tx_baud_n  = '0;
          tx_state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (tx_baud == BAUD_LAST) begin
          tx_baud_n  = '0;
          tx_shift_n = {1'b1, tx_shift[7:1]};
          tx_bit_n   = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (tx_baud == BAUD_LAST) begin
          tx_baud_n = '0;
          if (!fifo_empty) begin
            tx_pop     = 1'b1;
            tx_shift_n = fifo_rdata;
            tx_bit_n   = '0;
            tx_state_n = S_START;
          end else begin
            tx_state_n = S_IDLE;
          end
        end
      end
      default: tx_state_n = S_IDLE;
    endcase
  end

  // TX control registers; reset aborts any frame and forces the line idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state <= S_IDLE;
      tx_bit   <= '0;
      tx_baud  <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_bit   <= tx_bit_n;
      tx_baud  <= tx_baud_n;
    end
  end

  // TX shift register; only meaningful while a frame is active.
  always_ff @(posedge clk) begin
    tx_shift <= tx_shift_n;
  end

  assign tx = (tx_state == S_START) ? 1'b0 :
              (tx_state == S_DATA)  ? tx_shift[0] : 1'b1;

  // RX synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX next state: mid-bit sampling, early return to IDLE after the stop sample.
  always_comb begin
    rx_state_n  = rx_state;
    rx_shift_n  = rx_shift;
    rx_bit_n    = rx_bit;
    rx_baud_n   = rx_baud + 1'b1;
    rx_done_ok  = 1'b0;
    rx_done_bad = 1'b0;
    case (rx_state)
      S_IDLE: begin
        rx_baud_n = '0;
        if (rx_prev && !rx_sync) rx_state_n = S_START;
      end
      S_START: begin
        if (rx_baud == BAUD_MID) begin
          rx_baud_n  = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_baud == BAUD_LAST) begin
          rx_baud_n  = '0;
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_baud == BAUD_LAST) begin
          rx_state_n  = S_IDLE;
          rx_done_ok  = rx_sync;
          rx_done_bad = !rx_sync;
        end
      end
      default: rx_state_n = S_IDLE;
    endcase
  end

  // RX control registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_state <= S_IDLE;
      rx_bit   <= '0;
      rx_baud  <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_bit   <= rx_bit_n;
      rx_baud  <= rx_baud_n;
    end
  end

  // RX shift register; contents only matter once a full frame has been sampled.
  always_ff @(posedge clk) begin
    rx_shift <= rx_shift_n;
  end

  // Holding register and sticky flags; a hardware set beats a same-cycle read-clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (rx_done_ok) rx_byte <= rx_shift;
      if (rx_done_ok)   rx_valid <= 1'b1;
      else if (read_p1) rx_valid <= 1'b0;
      if (rx_done_ok && rx_valid) rx_overrun <= 1'b1;
      else if (read_p1)           rx_overrun <= 1'b0;
      if (rx_done_bad)  rx_frame_err <= 1'b1;
      else if (read_p1) rx_frame_err <= 1'b0;
    end
  end

endmodule

// File: doc/csr_uart.md
Name: csr_uart

Overview:
- Memory-less UART peripheral attached to the pipeline's CSR port at address CSR_UART (0xbc0).
- Provides a real serial TX/RX path for hardware builds, replacing the simulation-only character print.
- TX path: CSR writes enqueue bytes into a small FIFO; a serializer drains it as 8N1 frames.
- RX path: a deserializer captures one incoming byte into a holding register, which software reads through the same CSR.

Parameters:
CSR_UART, 12'hbc0, CSR address decoded by this block
CLOCK_DIVIDE, 868, clk cycles per bit (100 MHz / 115200)
FIFO_LOG, 3, log2 of TX FIFO depth (8 entries)

Ports:
clk  input  1  clock; all state on rising edge
rstn  input  1  asynchronous active-low reset
read  input  1  CSR read request, qualifies addr in the same cycle
modify  input  3  CSR modify opcode, refers to the address of the previous cycle
wdata  input  32  CSR write data, same cycle as modify
addr  input  12  CSR address
rdata  output  32  CSR read data, one cycle after read
valid  output  1  CSR access accepted, one cycle after addr hit
tx  output  1  serial out, idle high
rx  input  1  serial in, asynchronous

Behaviour:
- Reset: async on rstn low. rdata=0, valid=0, tx=1. FIFO empty, RX buffer empty, all flags clear. Any frame in progress is aborted; tx goes high immediately.
- CSR timing:
  - q_addr <= addr every cycle; q_hit = (q_addr==CSR_UART).
  - q_read <= read & (addr==CSR_UART).
  - valid = q_read | (q_hit & modify!=0), registered to line up with the data phase. rdata is 0 whenever q_read=0.
- Read value (data phase):
  - [7:0] rx byte
  - [8] rx_valid
  - [9] tx_full
  - [10] tx_idle (FIFO empty and serializer idle)
  - [11] rx_overrun
  - [12] rx_frame_err
  - [31:13] 0
- Read side effects, in the data-phase cycle: clears rx_valid, rx_overrun and rx_frame_err. The value returned is the pre-clear value.
- Write: modify==1 with q_hit pushes wdata[7:0] into the TX FIFO. If full, the byte is silently dropped. modify 2/3/others are ignored (no set/clear semantics).
- Read and write in the same access (CSRRW): return the old status and apply both side effects.
- TX FIFO:
  - Depth 2**FIFO_LOG; pointers are FIFO_LOG+1 bits for full/empty detection and wrap modulo 2**(FIFO_LOG+1).
  - Push and pop in the same cycle are both legal when not empty.
  - Push to an empty FIFO concurrent with the serializer's pop is not a pop: the serializer only pops when it sees count>0 at the start of the cycle.
- TX serializer FSM IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: if FIFO not empty, pop into the shift register and enter START.
  - START: tx=0 for CLOCK_DIVIDE cycles.
  - DATA: 8 bits LSB first, each CLOCK_DIVIDE cycles. A 3-bit bit counter and a baud counter of width clog2(CLOCK_DIVIDE) reload at every bit boundary.
  - STOP: tx=1 for CLOCK_DIVIDE cycles, then the next byte may start back-to-back with no extra idle cycle.
- RX:
  - Input passes a 2-flop synchronizer (reset value 1).
  - FSM IDLE -> START -> DATA -> STOP.
  - IDLE: a falling edge enters START.
  - START: sample at CLOCK_DIVIDE/2. If high, treat as a glitch and return to IDLE.
  - DATA: sample 8 bits at mid-bit spacing.
  - STOP: sample the stop bit. If high, load the byte and set rx_valid; set rx_overrun if rx_valid was already 1, with the new byte overwriting. If low, set rx_frame_err and discard the byte.
  - Return to IDLE after the stop sample (half a bit early for resync).
- A CSR read-clear and a hardware set in the same cycle: the set wins.

Decomposition:
- Shared package (csr_pkg): CSR_UART, CSR_SIM and the status bit index constants.
- One natural sub-module: sync_fifo (parameters WIDTH, LOG; ports clk, rstn, push, wdata, pop, rdata, empty, full).
- Serializer and deserializer stay inline.

Test Plan:
1. Reset mid-frame: write 0x41, drop rstn at bit 3 -> tx=1 within the same cycle. After release, read returns 0x400 (idle, empty).
2. TX single byte: write 0x55 with CLOCK_DIVIDE=4 -> tx shows start 0, then bits 1,0,1,0,1,0,1,0 and stop 1, 40 cycles total. Status then returns to tx_idle=1.
3. TX FIFO full/wrap: write 10 bytes 0x30..0x39 back-to-back during the first frame -> 9 bytes are serialized in order: 0x30 on the wire plus 8 in the FIFO. tx_full=1 reads as 0x200 set. The 10th byte is dropped. A later burst of 12 checks pointer wrap.
4. RX receive: drive 0xA5 frame -> read returns 0x1A5. A second read returns 0x0xx with bit8=0.
5. RX overrun and framing error: two frames 0x11, 0x22 without a read -> read 0x922 (valid+overrun). A frame with stop=0 -> bit12 set, rx_valid unchanged.
6. CSRRW at CSR_UART with rx_valid=1 -> returns the old status, the byte is popped and the wdata byte is queued. An access to another address (0x3ff) -> valid stays 0 and there are no side effects.
